// File: rtl/tanh_arbiter_pkg.sv
// tanh_arbiter_pkg: shared constants, helper function and tag type for the
// tanh sharing block.
//   FRAC_W       - width of a requester's fractional-bit count
//   IMM_W        - width of the unit's immediate operand
//   TANH_LATENCY - cycles from sampled input to valid unit output
//   TAG_ID_W     - tag ID storage width, sized for the maximum of 8 requesters
package tanh_arbiter_pkg;

  localparam int unsigned FRAC_W       = 6;
  localparam int unsigned IMM_W        = 32;
  localparam int unsigned TANH_LATENCY = 3;
  localparam int unsigned TAG_ID_W     = 3;

  // Ceiling log2; returns 0 for n <= 1
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  // One stage of the tag pipeline that shadows the shared unit
  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/tanh_rsp_fifo.sv
// tanh_rsp_fifo: first-word-fall-through FIFO with an occupancy count.
//   clk, reset  - clock, synchronous active-high reset
//   i_wr_en     - write i_wr_data at the next edge
//   i_rd_en     - pop the head at the next edge (ignored when empty)
//   o_rd_data   - current head entry
//   o_empty     - no entries held
//   o_count     - number of entries held
module tanh_rsp_fifo
  import tanh_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 35,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned CNT_W = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_full;
  logic              w_wr;
  logic              w_rd;

  // Pointer advance with explicit wrap so non-power-of-two depths work
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_rd      = i_rd_en & ~o_empty;
  // A write into a full FIFO is only legal when the head leaves in the same cycle
  assign w_wr      = i_wr_en & (~w_full | w_rd);
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  // Pointer and count state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CNT_W'(w_wr) - CNT_W'(w_rd);
    end
  end

  // Storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/tanh_arbiter.sv
// tanh_arbiter: shares one pipelined tanh unit between NUM_REQ requesters.
//   clk, reset      - clock, synchronous active-high reset
//   req_valid/ready - per-requester handshake; ready is one-hot on the grant
//   req_data/frac   - packed per-requester operands and fractional-bit counts
//   tanh_data_in0   - operand to the shared unit (0 when not issuing)
//   tanh_immediate  - zero-extended frac to the shared unit (0 when not issuing)
//   tanh_data_out   - unit result, aligned with the last tag stage
//   rsp_*           - FWFT response stream carrying result and requester ID
module tanh_arbiter
  import tanh_arbiter_pkg::*;
#(
  parameter int unsigned BIT_WIDTH    = 32,
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned UNIT_LATENCY = TANH_LATENCY,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned ID_W         = clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*BIT_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ*FRAC_W-1:0]     req_frac,
  output logic [BIT_WIDTH-1:0]          tanh_data_in0,
  output logic [IMM_W-1:0]              tanh_immediate,
  input  logic [BIT_WIDTH-1:0]          tanh_data_out,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [BIT_WIDTH-1:0]          rsp_data,
  output logic [ID_W-1:0]               rsp_id
);

  localparam int unsigned CNT_W  = clog2(FIFO_DEPTH + 1);
  localparam int unsigned CRED_W = clog2(FIFO_DEPTH + UNIT_LATENCY + 1) + 1;
  localparam int unsigned ENT_W  = TAG_ID_W + BIT_WIDTH;

  logic [ID_W-1:0]   r_ptr;
  tag_t              r_tag [UNIT_LATENCY];
  logic [ID_W-1:0]   w_grant_id;
  logic              w_grant_any;
  logic              w_can_issue;
  logic              w_issue;
  logic              w_pop;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_occ;
  logic [CRED_W-1:0] w_inflight;
  logic [ENT_W-1:0]  w_head;

  // Round-robin scan: first valid requester at or after r_ptr, wrapping
  always_comb begin
    int unsigned idx;
    idx         = 0;
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = k + 32'(r_ptr);
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_grant_any && req_valid[ID_W'(idx)]) begin
        w_grant_any = 1'b1;
        w_grant_id  = ID_W'(idx);
      end
    end
  end

  // Every valid tag stage holds a result that will need a FIFO slot
  always_comb begin
    w_inflight = '0;
    for (int unsigned s = 0; s < UNIT_LATENCY; s++) begin
      w_inflight = w_inflight + CRED_W'(r_tag[s].valid);
    end
  end

  assign rsp_valid   = ~w_fifo_empty;
  assign w_pop       = rsp_valid & rsp_ready;
  // A same-cycle pop frees a slot; pop implies occ >= 1 so no underflow
  assign w_can_issue = (w_inflight + CRED_W'(w_occ) - CRED_W'(w_pop)) < CRED_W'(FIFO_DEPTH);
  assign w_issue     = w_grant_any & w_can_issue & ~reset;

  // Grant and operand steering to the shared unit
  always_comb begin
    req_ready      = '0;
    tanh_data_in0  = '0;
    tanh_immediate = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_issue && (w_grant_id == ID_W'(i))) begin
        req_ready[i]   = 1'b1;
        tanh_data_in0  = req_data[i*BIT_WIDTH +: BIT_WIDTH];
        tanh_immediate = {{(IMM_W - FRAC_W){1'b0}}, req_frac[i*FRAC_W +: FRAC_W]};
      end
    end
  end

  // Round-robin pointer and tag pipeline shadowing the unit latency
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
      for (int unsigned s = 0; s < UNIT_LATENCY; s++) r_tag[s] <= '0;
    end else begin
      if (w_issue) begin
        r_ptr <= (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + ID_W'(1);
      end
      r_tag[0] <= '{valid: w_issue, id: TAG_ID_W'(w_grant_id)};
      for (int unsigned s = 1; s < UNIT_LATENCY; s++) r_tag[s] <= r_tag[s-1];
    end
  end

  tanh_rsp_fifo #(
    .DATA_W (ENT_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (r_tag[UNIT_LATENCY-1].valid),
    .i_wr_data ({r_tag[UNIT_LATENCY-1].id, tanh_data_out}),
    .i_rd_en   (w_pop),
    .o_rd_data (w_head),
    .o_empty   (w_fifo_empty),
    .o_count   (w_occ)
  );

  // Head is masked so an empty FIFO presents zeros
  assign rsp_data = rsp_valid ? w_head[BIT_WIDTH-1:0] : '0;
  assign rsp_id   = rsp_valid ? ID_W'(w_head[ENT_W-1:BIT_WIDTH]) : '0;

endmodule

// File: tb/tb_tanh_arbiter.sv
`timescale 1ns/1ps
module tb_tanh_arbiter;

  localparam int unsigned BW  = 32;
  localparam int unsigned NR  = 4;
  localparam int unsigned IDW = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [NR-1:0]  req_valid = '0;
  logic [NR-1:0]  req_ready;
  logic [NR*BW-1:0] req_data;
  logic [NR*6-1:0]  req_frac;
  logic [BW-1:0]  tanh_data_in0;
  logic [31:0]    tanh_immediate;
  logic [BW-1:0]  tanh_data_out;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic [BW-1:0]  rsp_data;
  logic [IDW-1:0] rsp_id;

  logic [BW-1:0]  op_d [NR];
  logic [5:0]     op_f [NR];

  // Behavioural stand-in for the shared unit: three-stage pipeline
  logic [BW-1:0]  u_s0 = '0, u_s1 = '0, u_s2 = '0;

  logic [IDW+BW-1:0] exp_q [$];
  logic [IDW+BW-1:0] obs_q [$];
  int                obs_cyc [$];
  int                grant_log [$];
  int                cyc = 0;
  int                n_pass = 0;
  int                n_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NR; g++) begin : g_pack
    assign req_data[g*BW +: BW] = op_d[g];
    assign req_frac[g*6 +: 6]   = op_f[g];
  end

  function automatic logic [31:0] unit_f(input logic [31:0] x, input logic [31:0] imm);
    return (x * 32'h9E37_79B1) ^ (imm << 26) ^ 32'h015A_5A5A;
  endfunction

  always @(posedge clk) begin
    u_s0 <= unit_f(tanh_data_in0, tanh_immediate);
    u_s1 <= u_s0;
    u_s2 <= u_s1;
  end
  assign tanh_data_out = u_s2;

  tanh_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_data       (req_data),
    .req_frac       (req_frac),
    .tanh_data_in0  (tanh_data_in0),
    .tanh_immediate (tanh_immediate),
    .tanh_data_out  (tanh_data_out),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_id         (rsp_id)
  );

  // Called at a negedge: samples handshakes and pops, then advances one cycle
  task automatic step();
    logic [NR-1:0] hs;
    #1;
    hs = req_valid & req_ready;
    for (int i = 0; i < NR; i++) begin
      if (hs[i]) begin
        grant_log.push_back(i);
        exp_q.push_back({IDW'(i), unit_f(op_d[i], {26'b0, op_f[i]})});
      end
    end
    if (rsp_valid && rsp_ready) begin
      obs_q.push_back({rsp_id, rsp_data});
      obs_cyc.push_back(cyc);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < NR; i++) begin
      op_d[i] = $urandom;
      op_f[i] = 6'($urandom_range(0, 31));
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < NR; i++) begin
      op_d[i] = '0;
      op_f[i] = '0;
    end
    reset     = 1'b1;
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if (req_ready !== 4'b0000) $display("FAIL reset_req_ready: got %b want 0000", req_ready);
    else n_pass++;
    n_total++;
    if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid);
    else n_pass++;
    n_total++;
    if (rsp_data !== '0) $display("FAIL reset_rsp_data: got %h want 0", rsp_data);
    else n_pass++;
    n_total++;
    if (rsp_id !== '0) $display("FAIL reset_rsp_id: got %0d want 0", rsp_id);
    else n_pass++;
    n_total++;
    if (tanh_data_in0 !== '0) $display("FAIL reset_data_in0: got %h want 0", tanh_data_in0);
    else n_pass++;
    n_total++;
    if (tanh_immediate !== '0) $display("FAIL reset_immediate: got %h want 0", tanh_immediate);
    else n_pass++;
    req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    int c0;
    logic [IDW+BW-1:0] got, want;
    obs_cyc.delete();
    randomize_ops();
    op_d[0]   = 32'h0000_0080;
    op_f[0]   = 6'd8;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    n_total++;
    if (req_ready !== 4'b0001) $display("FAIL single_ready: got %b want 0001", req_ready);
    else n_pass++;
    n_total++;
    if (tanh_immediate !== 32'h8) $display("FAIL single_imm: got %h want 00000008", tanh_immediate);
    else n_pass++;
    n_total++;
    if (tanh_data_in0 !== 32'h80) $display("FAIL single_data_in0: got %h want 00000080", tanh_data_in0);
    else n_pass++;
    c0 = cyc;
    step();
    req_valid = '0;
    repeat (8) step();
    n_total++;
    if (obs_cyc.size() != 1) $display("FAIL single_rsp_count: got %0d want 1", obs_cyc.size());
    else if (obs_cyc[0] - c0 != 4) $display("FAIL single_latency: got %0d want 4", obs_cyc[0] - c0);
    else n_pass++;
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      n_total++;
      if (exp_q.size() == 0) $display("FAIL single_rsp: got %h want none", got);
      else begin
        want = exp_q.pop_front();
        if (got !== want) $display("FAIL single_rsp: got %h want %h", got, want);
        else n_pass++;
      end
    end
  endtask

  task automatic test_pointer_skip();
    logic [NR-1:0] hs_now;
    logic [IDW+BW-1:0] got, want;
    int want_g [3] = '{2, 0, 3};
    grant_log.delete();
    randomize_ops();
    rsp_ready = 1'b1;
    req_valid = 4'b0101;
    for (int k = 0; k < 6 && req_valid != '0; k++) begin
      #1;
      hs_now = req_valid & req_ready;
      step();
      req_valid = req_valid & ~hs_now;
    end
    req_valid = 4'b1000;
    #1;
    hs_now = req_valid & req_ready;
    step();
    req_valid = req_valid & ~hs_now;
    n_total++;
    if (grant_log.size() != 3) $display("FAIL skip_grant_count: got %0d want 3", grant_log.size());
    else n_pass++;
    for (int i = 0; i < 3 && i < grant_log.size(); i++) begin
      n_total++;
      if (grant_log[i] != want_g[i]) $display("FAIL skip_grant[%0d]: got %0d want %0d", i, grant_log[i], want_g[i]);
      else n_pass++;
    end
    // Pointer must have wrapped to 0 after granting requester 3
    req_valid = 4'b1111;
    #1;
    n_total++;
    if (req_ready !== 4'b0001) $display("FAIL skip_wrap: got %b want 0001", req_ready);
    else n_pass++;
    req_valid = '0;
    step();
    repeat (6) step();
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      n_total++;
      if (exp_q.size() == 0) $display("FAIL skip_rsp: got %h want none", got);
      else begin
        want = exp_q.pop_front();
        if (got !== want) $display("FAIL skip_rsp: got %h want %h", got, want);
        else n_pass++;
      end
    end
  endtask

  task automatic test_round_robin();
    logic [IDW+BW-1:0] got, want;
    grant_log.delete();
    obs_cyc.delete();
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      randomize_ops();
      step();
    end
    req_valid = '0;
    repeat (8) step();
    n_total++;
    if (grant_log.size() != 6) $display("FAIL rr_grant_count: got %0d want 6", grant_log.size());
    else n_pass++;
    for (int i = 0; i < grant_log.size() && i < 6; i++) begin
      n_total++;
      if (grant_log[i] != i % 4) $display("FAIL rr_grant[%0d]: got %0d want %0d", i, grant_log[i], i % 4);
      else n_pass++;
    end
    n_total++;
    if (obs_cyc.size() != 6) $display("FAIL rr_rsp_count: got %0d want 6", obs_cyc.size());
    else if (obs_cyc[5] - obs_cyc[0] != 5) $display("FAIL rr_throughput: span got %0d want 5", obs_cyc[5] - obs_cyc[0]);
    else n_pass++;
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      n_total++;
      if (exp_q.size() == 0) $display("FAIL rr_rsp: got %h want none", got);
      else begin
        want = exp_q.pop_front();
        if (got !== want) $display("FAIL rr_rsp: got %h want %h", got, want);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [BW-1:0] held;
    logic [IDW+BW-1:0] got, want;
    int n_rsp;
    grant_log.delete();
    n_rsp     = 0;
    randomize_ops();
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    repeat (8) step();
    n_total++;
    if (grant_log.size() != 4) $display("FAIL bp_stall_issues: got %0d want 4", grant_log.size());
    else n_pass++;
    #1;
    n_total++;
    if (req_ready !== 4'b0000) $display("FAIL bp_stalled_ready: got %b want 0000", req_ready);
    else n_pass++;
    held = rsp_data;
    step();
    #1;
    n_total++;
    if (rsp_valid !== 1'b1 || rsp_data !== held) $display("FAIL bp_hold: got valid %b data %h want 1 %h", rsp_valid, rsp_data, held);
    else n_pass++;
    rsp_ready = 1'b1;
    #1;
    n_total++;
    if (req_ready === 4'b0000) $display("FAIL bp_pop_issue: got ready %b want one-hot", req_ready);
    else n_pass++;
    for (int k = 0; k < 20 && grant_log.size() < 8; k++) step();
    req_valid = '0;
    repeat (10) step();
    n_total++;
    if (grant_log.size() != 8) $display("FAIL bp_total_issues: got %0d want 8", grant_log.size());
    else n_pass++;
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      n_rsp++;
      n_total++;
      if (exp_q.size() == 0) $display("FAIL bp_rsp: got %h want none", got);
      else begin
        want = exp_q.pop_front();
        if (got !== want) $display("FAIL bp_rsp: got %h want %h", got, want);
        else n_pass++;
      end
    end
    n_total++;
    if (n_rsp != 8) $display("FAIL bp_rsp_count: got %0d want 8", n_rsp);
    else n_pass++;
  endtask

  task automatic test_full_simul();
    logic [IDW+BW-1:0] got, want;
    grant_log.delete();
    randomize_ops();
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    repeat (6) step();
    // Now 3 results held and one in flight: credits exhausted
    #1;
    n_total++;
    if (grant_log.size() != 4 || req_ready !== 4'b0000) $display("FAIL full_blocked: got issues %0d ready %b want 4 0000", grant_log.size(), req_ready);
    else n_pass++;
    rsp_ready = 1'b1;
    #1;
    n_total++;
    if (rsp_valid !== 1'b1 || req_ready === 4'b0000) $display("FAIL full_pop_issue: got valid %b ready %b want 1 one-hot", rsp_valid, req_ready);
    else n_pass++;
    step();
    rsp_ready = 1'b0;
    #1;
    n_total++;
    if (req_ready !== 4'b0000) $display("FAIL full_occupancy: got ready %b want 0000", req_ready);
    else n_pass++;
    step();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (10) step();
    n_total++;
    if (grant_log.size() != 5) $display("FAIL full_issues: got %0d want 5", grant_log.size());
    else n_pass++;
    while (obs_q.size() > 0) begin
      got = obs_q.pop_front();
      n_total++;
      if (exp_q.size() == 0) $display("FAIL full_rsp: got %h want none", got);
      else begin
        want = exp_q.pop_front();
        if (got !== want) $display("FAIL full_rsp: got %h want %h", got, want);
        else n_pass++;
      end
    end
    n_total++;
    if (exp_q.size() != 0) $display("FAIL full_lost: got %0d outstanding want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    randomize_ops();
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    repeat (3) step();
    req_valid = '0;
    reset     = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    obs_q.delete();
    #1;
    n_total++;
    if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0) $display("FAIL midrst_outputs: got valid %b data %h id %0d want 0 0 0", rsp_valid, rsp_data, rsp_id);
    else n_pass++;
    req_valid = 4'b1111;
    #1;
    n_total++;
    if (req_ready !== 4'b0001) $display("FAIL midrst_ptr: got %b want 0001", req_ready);
    else n_pass++;
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    repeat (5) step();
    n_total++;
    if (obs_q.size() != 0) $display("FAIL midrst_stale: got %0d responses want 0", obs_q.size());
    else n_pass++;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_pointer_skip();
    test_round_robin();
    test_back_pressure();
    test_full_simul();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
